// File: rtl/mainfsm_wait.sv
// mainfsm_wait: multicycle ARM control FSM with bus wait states and a sticky fault state.
// Define MAINFSM_TIMEOUT_EN to fault an access after 2^TIMEOUT_W consecutive not-ready cycles.
module mainfsm_wait #(
    parameter int TIMEOUT_W   = 4,
    parameter bit UNDEF_FAULT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       Fault,
    output logic [1:0] FaultCause,
    output logic [3:0] StateOut
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        FAULT    = 4'd10
    } state_t;

    state_t      state_q, state_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;
    logic        access;
    logic        timeout;
    logic        fetch_go;
    logic [12:0] ctl;
    logic        unused_funct;

    assign unused_funct = ^Funct[4:1];
    assign access       = state_q inside {FETCH, MEMRD, MEMWR};

`ifdef MAINFSM_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    assign timeout = access && !MemReady && (cnt_q == '1);

    always_comb begin
        cnt_d = (state_d != state_q) ? '0 :
                (access && !MemReady && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    localparam int unused_timeout_w = TIMEOUT_W;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:              state_d = MemReady ? DECODE : FETCH;
            DECODE:             state_d = (Op == 2'b00) ? (Funct[5] ? EXECUTEI : EXECUTER) :
                                          (Op == 2'b01) ? MEMADR :
                                          (Op == 2'b10) ? BRANCH :
                                          (UNDEF_FAULT ? FAULT : FETCH);
            EXECUTER, EXECUTEI: state_d = ALUWB;
            MEMADR:             state_d = Funct[0] ? MEMRD : MEMWR;
            MEMRD:              state_d = MemReady ? MEMWB : MEMRD;
            MEMWR:              state_d = MemReady ? FETCH : MEMWR;
            ALUWB, MEMWB, BRANCH: state_d = FETCH;
            FAULT:              state_d = FAULT;
            default:            state_d = FETCH;
        endcase
        if (timeout)
            state_d = FAULT;
    end

    // Cause is latched only on the entering transition, so it never changes while in FAULT.
    always_comb begin
        fault_d = fault_q | (state_d == FAULT);
        cause_d = (state_d == FAULT && state_q != FAULT) ? (timeout ? 2'b10 : 2'b01) : cause_q;
    end

    assign fetch_go = MemReady & ~reset;

    // ctl = {MemReq, NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
    always_comb begin
        ctl = '0;
        case (state_q)
            FETCH:    ctl = {1'b1, fetch_go, 3'b000, fetch_go, 7'b0_10_1_10_0};
            DECODE:   ctl = 13'b0_00000_0_10_1_10_0;
            EXECUTER: ctl = 13'b0_00000_0_00_0_00_1;
            EXECUTEI: ctl = 13'b0_00000_0_00_0_01_1;
            ALUWB:    ctl = 13'b0_00010_0_00_0_00_0;
            MEMADR:   ctl = 13'b0_00000_0_00_0_01_0;
            MEMRD:    ctl = 13'b1_00000_1_00_0_00_0;
            MEMWR:    ctl = 13'b1_00100_1_00_0_00_0;
            MEMWB:    ctl = 13'b0_00010_0_01_0_00_0;
            BRANCH:   ctl = 13'b0_01000_0_10_0_01_0;
            default:  ctl = '0;
        endcase
    end

    assign {MemReq, NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp} = ctl;
    assign StateOut   = state_q;
    assign Fault      = fault_q;
    assign FaultCause = cause_q;
endmodule

// File: tb/tb_mainfsm_wait.sv
// tb_mainfsm_wait: vector table, corner sequences and a random run against a route-based model.
module tb_mainfsm_wait;
    localparam int TW = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'b0;
    logic       ready = 1'b1;

    logic       MemReq, IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, Branch, ALUOp, Fault;
    logic [1:0] ALUSrcB, ResultSrc, FaultCause;
    logic [3:0] StateOut;
    logic       MemReq0, IRWrite0, NextPC0, AdrSrc0, ALUSrcA0, RegW0, MemW0, Branch0, ALUOp0, Fault0;
    logic [1:0] ALUSrcB0, ResultSrc0, FaultCause0;
    logic [3:0] StateOut0;
    logic [12:0] ctl1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mainfsm_wait #(.TIMEOUT_W(TW), .UNDEF_FAULT(1'b1)) u_dut (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(ready),
        .MemReq(MemReq), .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .RegW(RegW), .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .Fault(Fault), .FaultCause(FaultCause), .StateOut(StateOut)
    );

    mainfsm_wait #(.TIMEOUT_W(TW), .UNDEF_FAULT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .MemReady(ready),
        .MemReq(MemReq0), .IRWrite(IRWrite0), .NextPC(NextPC0), .AdrSrc(AdrSrc0), .ALUSrcA(ALUSrcA0),
        .RegW(RegW0), .MemW(MemW0), .Branch(Branch0), .ALUOp(ALUOp0), .ALUSrcB(ALUSrcB0),
        .ResultSrc(ResultSrc0), .Fault(Fault0), .FaultCause(FaultCause0), .StateOut(StateOut0)
    );

    assign ctl1 = {MemReq, NextPC, Branch, MemW, RegW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Control word per state straight from the output table.
    function automatic logic [12:0] exp_ctl(input int s, input logic r);
        case (s)
            0:       return {1'b1, r, 3'b000, r, 7'b0101100};
            1:       return 13'b0000000101100;
            2:       return 13'b0000000000010;
            3:       return 13'b1000001000000;
            4:       return 13'b0000100010000;
            5:       return 13'b1001001000000;
            6:       return 13'b0000000000001;
            7:       return 13'b0000000000011;
            8:       return 13'b0000100000000;
            9:       return 13'b0010000100010;
            default: return 13'b0;
        endcase
    endfunction

    // Model: queue of upcoming states; the instruction route is chosen when DECODE retires.
    int         m_path[$];
    int         m_wait;
    logic       m_fault;
    logic [1:0] m_cause;

    task automatic m_reset();
        m_path.delete();
        m_path.push_back(0);
        m_wait = 0;
        m_fault = 1'b0;
        m_cause = 2'b00;
    endtask

    task automatic m_route(input int a, input int b, input int c, input int d);
        if (a >= 0) m_path.push_back(a);
        if (b >= 0) m_path.push_back(b);
        if (c >= 0) m_path.push_back(c);
        if (d >= 0) m_path.push_back(d);
    endtask

    task automatic m_step(input logic r, input logic [1:0] o, input logic [5:0] f);
        int s;
        int dummy;
        s = m_path[0];
        if (s == 10) return;
        if ((s == 0 || s == 3 || s == 5) && !r) begin
`ifdef MAINFSM_TIMEOUT_EN
            if (m_wait == (1 << TW) - 1) begin
                m_path.delete();
                m_path.push_back(10);
                m_fault = 1'b1;
                m_cause = 2'b10;
                m_wait = 0;
                return;
            end
`endif
            m_wait++;
            return;
        end
        m_wait = 0;
        dummy = m_path.pop_front();
        if (s == 0) m_route(1, -1, -1, -1);
        else if (s == 1) begin
            case (o)
                2'b00:   m_route(f[5] ? 7 : 6, 8, 0, -1);
                2'b01:   if (f[0]) m_route(2, 3, 4, 0); else m_route(2, 5, 0, -1);
                2'b10:   m_route(9, 0, -1, -1);
                default: begin
                    m_route(10, -1, -1, -1);
                    m_fault = 1'b1;
                    m_cause = 2'b01;
                end
            endcase
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic cyc(input logic r);
        ready = r;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        int fw;
        int mw;
        int cycles;
        int regw_at;
        int memw_n;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int st, fl, ml, n_cyc, irn, npn, ir_at, rn, r_at, mn, miss, stall;
        logic left;
        vecs[0] = '{2'b00, 6'b001000, 0, 0, 4, 4, 0};
        vecs[1] = '{2'b00, 6'b101000, 0, 0, 4, 4, 0};
        vecs[2] = '{2'b01, 6'b000001, 3, 2, 10, 10, 0};
        vecs[3] = '{2'b01, 6'b000001, 0, 0, 5, 5, 0};
        vecs[4] = '{2'b01, 6'b000000, 0, 1, 5, 0, 2};
        vecs[5] = '{2'b01, 6'b000000, 2, 0, 6, 0, 1};
        vecs[6] = '{2'b10, 6'b000000, 0, 0, 3, 0, 0};

        #1;
        chk("rst_state", StateOut, 0);
        chk("rst_fault", {Fault, FaultCause}, 0);
        chk("rst_irwrite", {IRWrite, NextPC}, 0);
        chk("rst_memreq", MemReq, 1);
        #5;
        reset = 1'b0;

        foreach (vecs[k]) begin
            do_reset();
            op = vecs[k].op;
            funct = vecs[k].funct;
            fl = 0; ml = 0; n_cyc = 0; irn = 0; npn = 0; ir_at = 0; rn = 0; r_at = 0; mn = 0; miss = 0;
            left = 1'b0;
            for (int n = 1; n <= 40 && n_cyc == 0; n++) begin
                st = int'(StateOut);
                if (st == 0 && fl < vecs[k].fw) begin ready = 1'b0; fl++; end
                else if ((st == 3 || st == 5) && ml < vecs[k].mw) begin ready = 1'b0; ml++; end
                else ready = 1'b1;
                #1;
                if (IRWrite) begin irn++; ir_at = n; end
                if (NextPC) npn++;
                if (RegW) begin rn++; r_at = n; end
                if (MemW) mn++;
                if ((st == 0 || st == 3) && !MemReq) miss++;
                if (st != 0) left = 1'b1;
                @(posedge clk);
                #1;
                if (left && StateOut == 0) n_cyc = n;
            end
            chk($sformatf("v%0d_cycles", k), n_cyc, vecs[k].cycles);
            chk($sformatf("v%0d_irwrite", k), {irn[7:0], ir_at[7:0]}, {8'd1, 8'(vecs[k].fw + 1)});
            chk($sformatf("v%0d_nextpc", k), npn, 1);
            chk($sformatf("v%0d_regw", k), {rn[7:0], r_at[7:0]}, {8'(vecs[k].regw_at != 0), 8'(vecs[k].regw_at)});
            chk($sformatf("v%0d_memw", k), mn, vecs[k].memw_n);
            chk($sformatf("v%0d_memreq", k), miss, 0);
        end

        do_reset();
        op = 2'b11;
        cyc(1'b1);
        chk("undef_decode", StateOut, 1);
        cyc(1'b1);
        chk("undef_fault_state", StateOut, 10);
        chk("undef_fault_flag", {Fault, FaultCause}, 3'b101);
        chk("undef_ctl", ctl1, 0);
        chk("undef0_state", StateOut0, 0);
        chk("undef0_fault", {Fault0, FaultCause0}, 0);
        for (int i = 0; i < 20; i++) cyc(1'($urandom));
        ready = 1'b1;
        #1;
        chk("undef_hold_state", StateOut, 10);
        chk("undef_hold_ctl", ctl1, 0);
        chk("undef_hold_flag", {Fault, FaultCause}, 3'b101);
        chk("undef0_hold_fault", Fault0, 0);
        do_reset();
        chk("undef_reset_state", StateOut, 0);
        chk("undef_reset_flag", {Fault, FaultCause}, 0);

        do_reset();
        op = 2'b00;
        funct = 6'b0;
        for (int i = 0; i < 15; i++) cyc(1'b0);
        chk("wait15_state", StateOut, 0);
        cyc(1'b1);
        chk("wait15_decode", StateOut, 1);
        chk("wait15_fault", Fault, 0);
        do_reset();
`ifdef MAINFSM_TIMEOUT_EN
        for (int i = 0; i < 16; i++) cyc(1'b0);
        chk("timeout_state", StateOut, 10);
        chk("timeout_flag", {Fault, FaultCause}, 3'b110);
`else
        for (int i = 0; i < 100; i++) cyc(1'b0);
        chk("notimeout_state", StateOut, 0);
        chk("notimeout_flag", {Fault, FaultCause}, 0);
`endif

        do_reset();
        op = 2'b01;
        funct = 6'b000001;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        chk("memrd_wait_state", StateOut, 3);
        reset = 1'b1;
        ready = 1'b1;
        #1;
        chk("async_rst_state", StateOut, 0);
        chk("async_rst_strobes", {IRWrite, NextPC}, 0);
        @(posedge clk);
        #1;
        chk("rst_held_strobes", {IRWrite, NextPC}, 0);
        reset = 1'b0;
        #1;
        chk("rel_fetch_strobes", {IRWrite, NextPC}, 2'b11);
        @(posedge clk);
        #1;
        chk("rel_decode", StateOut, 1);

        do_reset();
        m_reset();
        stall = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_path[0] == 0) begin
                op = 2'($urandom);
                if (op == 2'b11 && $urandom_range(0, 3) != 0) op = 2'($urandom_range(0, 2));
                funct = 6'($urandom);
            end
            if (stall == 0 && $urandom_range(0, 59) == 0) stall = $urandom_range(13, 17);
            ready = (stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (stall > 0) stall--;
            if ((m_path[0] == 10 && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1;
                chk("rnd_rst_state", StateOut, 0);
                chk("rnd_rst_strobes", {IRWrite, NextPC}, 0);
                reset = 1'b0;
                m_reset();
            end
            #1;
            chk("rnd_state", StateOut, m_path[0]);
            chk("rnd_ctl", ctl1, exp_ctl(m_path[0], ready));
            chk("rnd_fault", {Fault, FaultCause}, {m_fault, m_cause});
            @(posedge clk);
            m_step(ready, op, funct);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
